// File: rtl/akuma_motion_ctrl.sv
// Akuma per-frame motion controller: walk/jump physics on each vsync falling
// edge, driving registered sprite position and facing for the renderers.
`timescale 1ns/1ps
module akuma_motion_ctrl #(
  parameter int         INIT_X     = 100,
  parameter int         GROUND_Y   = 240,
  parameter int         X_MAX      = 499,
  parameter int         WALK_SPEED = 4,
  parameter int         JUMP_V     = 12,
  parameter int         GRAVITY    = 1,
  parameter logic [7:0] KEY_LEFT   = 8'h04,
  parameter logic [7:0] KEY_RIGHT  = 8'h07,
  parameter logic [7:0] KEY_JUMP   = 8'h1A
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       vs,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  output logic [9:0] AkumaX,
  output logic [9:0] AkumaY,
  output logic       facing_left,
  output logic       airborne,
  output logic       walking
);

  typedef enum logic {GROUND, AIR} state_t;

  localparam logic [10:0]        WS11  = 11'(WALK_SPEED);
  localparam logic [10:0]        XM11  = 11'(X_MAX);
  localparam logic signed [10:0] GY11  = 11'(GROUND_Y);
  localparam logic signed [7:0]  VJMP  = 8'(-JUMP_V);
  localparam logic signed [7:0]  VGRV  = 8'(GRAVITY);
  localparam logic [9:0]         X0    = 10'(INIT_X);
  localparam logic [9:0]         Y0    = 10'(GROUND_Y);

  state_t             r_state;
  logic               r_vs;
  logic signed [7:0]  r_vy;
  logic [9:0]         r_x;
  logic [9:0]         r_y;
  logic               r_face;
  logic               r_air;
  logic               r_walk;

  logic               w_tick;
  logic               w_l;
  logic               w_r;
  logic               w_j;
  logic [10:0]        w_x11;
  logic [10:0]        w_sum;
  logic [10:0]        w_nx;
  logic               w_move;
  logic signed [10:0] w_vy11;
  logic signed [10:0] w_ny;

  assign w_tick = r_vs & ~vs;

  assign w_l = (keycode0 == KEY_LEFT)  | (keycode1 == KEY_LEFT);
  assign w_r = (keycode0 == KEY_RIGHT) | (keycode1 == KEY_RIGHT);
  assign w_j = (keycode0 == KEY_JUMP)  | (keycode1 == KEY_JUMP);

  assign w_x11  = {1'b0, r_x};
  assign w_sum  = w_x11 + WS11;
  assign w_vy11 = {{3{r_vy[7]}}, r_vy};
  assign w_ny   = $signed({1'b0, r_y}) + w_vy11;

  // Horizontal target, saturated at both screen edges
  always_comb begin
    w_nx   = w_x11;
    w_move = 1'b0;
    if (w_l && !w_r) begin
      w_nx   = (w_x11 < WS11) ? 11'd0 : w_x11 - WS11;
      w_move = 1'b1;
    end else if (w_r && !w_l) begin
      w_nx   = (w_sum > XM11) ? XM11 : w_sum;
      w_move = 1'b1;
    end
  end

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      r_vs    <= 1'b1;
      r_state <= GROUND;
      r_vy    <= '0;
      r_x     <= X0;
      r_y     <= Y0;
      r_face  <= 1'b0;
      r_air   <= 1'b0;
      r_walk  <= 1'b0;
    end else begin
      r_vs <= vs;
      if (w_tick) begin
        r_x    <= w_nx[9:0];
        r_walk <= (w_nx != w_x11);
        if (w_move)
          r_face <= w_l;
        unique case (r_state)
          GROUND: begin
            r_y <= Y0;
            if (w_j) begin
              r_state <= AIR;
              r_vy    <= VJMP;
              r_air   <= 1'b1;
            end
          end
          AIR: begin
            // Landing absorbs all velocity; J is not looked at here
            if (w_ny >= GY11) begin
              r_state <= GROUND;
              r_y     <= Y0;
              r_vy    <= '0;
              r_air   <= 1'b0;
            end else begin
              r_y  <= w_ny[9:0];
              r_vy <= r_vy + VGRV;
            end
          end
          default: r_state <= GROUND;
        endcase
      end
    end
  end

  assign AkumaX      = r_x;
  assign AkumaY      = r_y;
  assign facing_left = r_face;
  assign airborne    = r_air;
  assign walking     = r_walk;

endmodule

// File: tb/tb_akuma_motion_ctrl.sv
// Bench for akuma_motion_ctrl: closed-form jump model checked every cycle,
// plus directed literal checks.
`timescale 1ns/1ps
module tb_akuma_motion_ctrl;

  localparam int IX = 100;
  localparam int GY = 240;
  localparam int XM = 499;
  localparam int WS = 4;
  localparam int JV = 12;
  localparam int GR = 1;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       vs = 1'b1;
  logic [7:0] k0 = 8'h00;
  logic [7:0] k1 = 8'h00;
  logic [9:0] AkumaX;
  logic [9:0] AkumaY;
  logic       facing_left;
  logic       airborne;
  logic       walking;

  akuma_motion_ctrl dut (
    .vga_clk    (clk),
    .Reset      (Reset),
    .vs         (vs),
    .keycode0   (k0),
    .keycode1   (k1),
    .AkumaX     (AkumaX),
    .AkumaY     (AkumaY),
    .facing_left(facing_left),
    .airborne   (airborne),
    .walking    (walking)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  int mx, my, mk, mair, mface, mwalk;

  function automatic void model_reset();
    mx = IX; my = GY; mk = 0;
    mair = 0; mface = 0; mwalk = 0;
  endfunction

  // Jump height as a closed-form function of air ticks since launch
  function automatic void model_tick();
    bit l, r, j;
    int nx, yy;
    l = (k0 == 8'h04) || (k1 == 8'h04);
    r = (k0 == 8'h07) || (k1 == 8'h07);
    j = (k0 == 8'h1A) || (k1 == 8'h1A);
    nx = mx;
    if (l && !r) begin
      nx = (mx - WS < 0) ? 0 : mx - WS;
      mface = 1;
    end else if (r && !l) begin
      nx = (mx + WS > XM) ? XM : mx + WS;
      mface = 0;
    end
    mwalk = (nx != mx);
    mx = nx;
    if (mair == 0) begin
      if (j) begin
        mair = 1;
        mk = 0;
      end
    end else begin
      mk++;
      yy = GY - JV * mk + GR * mk * (mk - 1) / 2;
      if (yy >= GY) begin
        my = GY;
        mair = 0;
      end else begin
        my = yy;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (chk_en) begin
      #1;
      n_chk++;
      if (AkumaX !== 10'(mx) || AkumaY !== 10'(my) ||
          facing_left !== 1'(mface) || airborne !== 1'(mair) ||
          walking !== 1'(mwalk)) begin
        n_fail++;
        $display("FAIL model t=%0t got x=%0d y=%0d f=%b a=%b w=%b exp x=%0d y=%0d f=%0d a=%0d w=%0d",
                 $time, AkumaX, AkumaY, facing_left, airborne, walking,
                 mx, my, mface, mair, mwalk);
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    Reset = 1'b1;
    vs = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    Reset = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    vs = 1'b0;
    model_tick();
    @(negedge clk);
    vs = 1'b1;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    model_reset();
    #1 chk_en = 1'b1;
    do_reset();
    chk("rst_x", 16'(AkumaX), 16'd100);
    chk("rst_y", 16'(AkumaY), 16'd240);

    // Keys wiggled between ticks must not matter
    @(negedge clk); k0 = 8'h04;
    repeat (3) @(negedge clk);
    k0 = 8'h00;
    ticks(3);
    chk("idle_x", 16'(AkumaX), 16'd100);
    chk("idle_w", 16'(walking), 16'd0);

    k0 = 8'h04;
    ticks(5);
    chk("left5_x", 16'(AkumaX), 16'd80);
    chk("left5_f", 16'(facing_left), 16'd1);
    chk("left5_w", 16'(walking), 16'd1);
    k1 = 8'h07;
    tick();
    chk("lr_x", 16'(AkumaX), 16'd80);
    chk("lr_w", 16'(walking), 16'd0);
    chk("lr_f", 16'(facing_left), 16'd1);
    k0 = 8'h00; k1 = 8'h00;

    do_reset();
    k0 = 8'h04;
    ticks(25);
    chk("lclamp_x", 16'(AkumaX), 16'd0);
    chk("lclamp_w1", 16'(walking), 16'd1);
    ticks(5);
    chk("lclamp_w0", 16'(walking), 16'd0);
    k0 = 8'h07;
    ticks(130);
    chk("rclamp_x", 16'(AkumaX), 16'd499);
    chk("rclamp_w", 16'(walking), 16'd0);
    chk("rclamp_f", 16'(facing_left), 16'd0);
    k0 = 8'h00;

    do_reset();
    k1 = 8'h1A;
    tick();
    k1 = 8'h00;
    chk("launch_a", 16'(airborne), 16'd1);
    chk("launch_y", 16'(AkumaY), 16'd240);
    ticks(6);
    chk("air6_y", 16'(AkumaY), 16'd183);
    ticks(6);
    chk("peak_y", 16'(AkumaY), 16'd162);
    ticks(12);
    chk("air24_y", 16'(AkumaY), 16'd228);
    chk("air24_a", 16'(airborne), 16'd1);
    tick();
    chk("land_y", 16'(AkumaY), 16'd240);
    chk("land_a", 16'(airborne), 16'd0);

    do_reset();
    k0 = 8'h07; k1 = 8'h1A;
    ticks(26);
    chk("jr_x", 16'(AkumaX), 16'd204);
    chk("jr_land_a", 16'(airborne), 16'd0);
    tick();
    chk("jr_relaunch", 16'(airborne), 16'd1);

    do_reset();
    tick();
    k1 = 8'h00;
    ticks(5);
    chk("pre_rst_y", 16'(AkumaY), 16'd190);
    chk("pre_rst_x", 16'(AkumaX), 16'd124);
    @(negedge clk);
    Reset = 1'b1;
    model_reset();
    #1;
    chk("midrst_x", 16'(AkumaX), 16'd100);
    chk("midrst_y", 16'(AkumaY), 16'd240);
    chk("midrst_a", 16'(airborne), 16'd0);
    @(negedge clk);
    Reset = 1'b0;
    k0 = 8'h00;
    ticks(2);
    chk("post_rst_y", 16'(AkumaY), 16'd240);

    // Long vs-low window: one update on the fall, none while low or on rise
    k0 = 8'h07;
    @(negedge clk);
    vs = 1'b0;
    model_tick();
    repeat (40) @(negedge clk);
    vs = 1'b1;
    repeat (10) @(negedge clk);
    chk("vslow_x", 16'(AkumaX), 16'd104);
    ticks(2);
    chk("vs2_x", 16'(AkumaX), 16'd112);
    k0 = 8'h00;
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
